fir_sample_feeder: RTL

Drives the input side of the team's 8-tap fully parallel FIR: it accepts 16-bit samples over a valid/ready stream and buffers them in a small FIFO. It issues them to the filter as a registered `filter_in` value qualified by a one-cycle `clk_enable` strobe at a programmable sample rate. On underflow it zero-stuffs so the filter's sample rate never slips. After an end-of-packet sample it flushes the filter with zeros so that `filter_out` returns to zero.

---
 rtl/fir_sample_feeder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: buffers upstream samples and strobes them into the
// parallel FIR at a programmable rate, zero-stuffing and flushing.
module fir_sample_feeder #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TAPS       = 8,
    parameter int DIV_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic [DATA_W-1:0] filter_in,
    output logic              clk_enable,
    output logic              busy,
    output logic              flush_done,
    output logic [15:0]       underflow_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(TAPS + 2);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [FW-1:0] FLUSH_N = FW'(TAPS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    logic [DATA_W:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    state_t            state_q;
    state_t            state_d;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_d;
    logic [FW-1:0]     flush_q;
    logic [FW-1:0]     flush_d;
    logic [DATA_W-1:0] filt_q;
    logic [DATA_W-1:0] filt_d;
    logic              ce_q;
    logic              ce_d;
    logic              done_q;
    logic              done_d;
    logic              busy_q;
    logic [15:0]       unf_q;
    logic [15:0]       unf_d;

    logic              push;
    logic              pop;
    logic              empty;
    logic              active;
    logic              tick;
    logic [DATA_W:0]   head;

    assign s_ready       = (count_q != DEPTH_C);
    assign empty         = (count_q == '0);
    assign push          = s_valid && s_ready;
    assign head          = mem_q[rd_ptr_q];
    assign filter_in     = filt_q;
    assign clk_enable    = ce_q;
    assign busy          = busy_q;
    assign flush_done    = done_q;
    assign underflow_cnt = unf_q;

    // FIFO storage; entries carry the last flag above the sample
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_last, s_data};
        end
    end

    // FIFO occupancy follows push/pop
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // sequencer: rate divider, pop/stuff/flush decisions, output staging
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        flush_d = flush_q;
        filt_d  = filt_q;
        ce_d    = 1'b0;
        done_d  = 1'b0;
        unf_d   = unf_q;
        pop     = 1'b0;
        active  = enable && (state_q != IDLE);
        tick    = active && (div_q >= rate_div);
        if (active) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                div_d = '0;
                if (enable && !empty) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    ce_d = 1'b1;
                    if (!empty) begin
                        pop    = 1'b1;
                        filt_d = head[DATA_W-1:0];
                        if (head[DATA_W]) begin
                            flush_d = FLUSH_N;
                            state_d = FLUSH;
                        end
                    end else begin
                        filt_d = '0;
                        if (unf_q != 16'hFFFF) begin
                            unf_d = unf_q + 16'd1;
                        end
                    end
                end
            end
            FLUSH: begin
                if (tick) begin
                    if (flush_q == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ce_d    = 1'b1;
                        filt_d  = '0;
                        flush_d = flush_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers; reset discards any buffered data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            div_q    <= '0;
            flush_q  <= '0;
            filt_q   <= '0;
            ce_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            unf_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            state_q <= state_d;
            div_q   <= div_d;
            flush_q <= flush_d;
            filt_q  <= filt_d;
            ce_q    <= ce_d;
            done_q  <= done_d;
            busy_q  <= (state_d != IDLE);
            unf_q   <= unf_d;
        end
    end

endmodule
